// File: rtl/mem_access_ctrl.sv
// Serialises the control unit's level memory enables into a req/ack stream on a
// single-port memory, capturing fetched words and the operand, and stalling the unit.
module mem_access_ctrl #(
  parameter int AW      = 8,
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem1RE,
  input  logic          mem2RE,
  input  logic          mem3RE,
  input  logic          mem4RE,
  input  logic          memWE,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] opAddr,
  input  logic [DW-1:0] wdata,
  output logic          stall,
  output logic [DW-1:0] instr1,
  output logic [DW-1:0] instr2,
  output logic [DW-1:0] instr3,
  output logic [DW-1:0] opData,
  output logic          busErr,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [1:0]    dbg_state_o
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DONE = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [4:0]    pend_q, pend_d;
  logic [AW-1:0] pc_q, pc_d, opa_q, opa_d;
  logic [DW-1:0] wd_q, wd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] instr1_q, instr1_d, instr2_q, instr2_d, instr3_q, instr3_d;
  logic [DW-1:0] opdata_q, opdata_d;
  logic          buserr_q, buserr_d;

  logic [4:0]    en;
  logic [4:0]    cur;
  logic          timed_out;
  logic          complete;
  logic [DW-1:0] cap_data;

  // Bit order is also issue priority: word1, word2, word3, operand read, write.
  assign en        = {memWE, mem4RE, mem3RE, mem2RE, mem1RE};
  assign cur       = pend_q & (~pend_q + 5'd1);
  assign timed_out = (cnt_q == CW'(TIMEOUT - 1));
  assign complete  = mem_req & (mem_ack | timed_out);
  assign cap_data  = mem_ack ? mem_rdata : '0;

  assign stall       = (|en) && (state_q != S_DONE);
  assign mem_req     = (state_q == S_ISSUE);
  assign mem_we      = cur[4];
  assign mem_wdata   = wd_q;
  assign instr1      = instr1_q;
  assign instr2      = instr2_q;
  assign instr3      = instr3_q;
  assign opData      = opdata_q;
  assign busErr      = buserr_q;
  assign dbg_state_o = state_q;

  always_comb begin
    mem_addr = opa_q;
    if (cur[0])      mem_addr = pc_q;
    else if (cur[1]) mem_addr = pc_q + AW'(1);
    else if (cur[2]) mem_addr = pc_q + AW'(2);
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    pc_d     = pc_q;
    opa_d    = opa_q;
    wd_d     = wd_q;
    cnt_d    = cnt_q;
    instr1_d = instr1_q;
    instr2_d = instr2_q;
    instr3_d = instr3_q;
    opdata_d = opdata_q;
    buserr_d = buserr_q;
    case (state_q)
      S_IDLE: begin
        if (|en) begin
          pend_d  = en;
          pc_d    = pc;
          opa_d   = opAddr;
          wd_d    = wdata;
          cnt_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (complete) begin
          pend_d = pend_q & ~cur;
          cnt_d  = '0;
          if (cur[0]) instr1_d = cap_data;
          if (cur[1]) instr2_d = cap_data;
          if (cur[2]) instr3_d = cap_data;
          if (cur[3]) opdata_d = cap_data;
          if (!mem_ack) buserr_d = 1'b1;
          if ((pend_q & ~cur) == 5'd0) state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pend_q   <= '0;
      pc_q     <= '0;
      opa_q    <= '0;
      wd_q     <= '0;
      cnt_q    <= '0;
      instr1_q <= '0;
      instr2_q <= '0;
      instr3_q <= '0;
      opdata_q <= '0;
      buserr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      pc_q     <= pc_d;
      opa_q    <= opa_d;
      wd_q     <= wd_d;
      cnt_q    <= cnt_d;
      instr1_q <= instr1_d;
      instr2_q <= instr2_d;
      instr3_q <= instr3_d;
      opdata_q <= opdata_d;
      buserr_q <= buserr_d;
    end
  end

endmodule
